mem_port_arbiter: RTL and testbench

- Shares the single read/write data port (port B) of the unified memory between several bus masters: CPU load/store unit, UART program loader and debug/trace reader.
- Sits between the masters and the memory top-level port B (address, write data, write enable, read data).
- Serialises accesses with a req/gnt handshake, returns read data with a per-requester valid pulse and enforces the block-RAM read latency.

---
 rtl/mem_port_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares memory port B between several bus masters.
// Accesses are serialised with a req/gnt handshake. Read data returns with a
// one-cycle valid pulse for the requester, after the block-RAM read latency.
module mem_port_arbiter #(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter bit          PRIO0_FIXED  = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ-1:0]         we_i,
    input  logic [NUM_REQ*DATA_W-1:0]  addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]  wdata_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         rvalid_o,
    output logic [DATA_W-1:0]          rdata_o,
    output logic [DATA_W-1:0]          mem_addr_o,
    output logic [DATA_W-1:0]          mem_wdata_o,
    output logic                       mem_we_o,
    input  logic [DATA_W-1:0]          mem_rdata_i,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned SUM_W = ID_W + 1;
    localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               we_q, we_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [DATA_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               mem_we_q, mem_we_d;
    logic               busy_q, busy_d;

    logic               win_valid;
    logic [ID_W-1:0]    win_id;
    logic               win_we;
    logic [DATA_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;
    logic [SUM_W-1:0]   sum;
    logic [ID_W-1:0]    idx;

    // Pick the first requester after the pointer; requester 0 may override
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        sum       = '0;
        idx       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + SUM_W'(k);
            if (sum >= SUM_W'(NUM_REQ)) begin
                sum = sum - SUM_W'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!win_valid && req_i[idx] && !(PRIO0_FIXED && (idx == '0))) begin
                win_valid = 1'b1;
                win_id    = idx;
            end
        end
        if (PRIO0_FIXED && req_i[0]) begin
            win_valid = 1'b1;
            win_id    = '0;
        end
    end

    // Select the winner's access fields
    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_we    = we_i[i];
                win_addr  = addr_i[i*DATA_W +: DATA_W];
                win_wdata = wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and registered-output logic for IDLE/ISSUE/WAIT
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        rvalid_d    = '0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    state_d     = S_ISSUE;
                    id_d        = win_id;
                    we_d        = win_we;
                    mem_addr_d  = win_addr;
                    mem_wdata_d = win_wdata;
                    mem_we_d    = win_we;
                    gnt_d       = NUM_REQ'(1) << win_id;
                    busy_d      = 1'b1;
                    if (!(PRIO0_FIXED && (win_id == '0))) begin
                        ptr_d = win_id;
                    end
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(READ_LATENCY - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                    rdata_d  = mem_rdata_i;
                    rvalid_d = NUM_REQ'(1) << id_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            ptr_q       <= ID_W'(NUM_REQ - 1);
            id_q        <= '0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_we_o    = mem_we_q;
    assign busy_o      = busy_q;
    assign grant_id_o  = id_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. Instance 0 uses fixed priority with
// READ_LATENCY=1. Instance 1 uses round-robin with READ_LATENCY=3.
module tb_mem_port_arbiter;
    localparam int unsigned NR = 3;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst_n;

    logic [NR-1:0]    req    [2];
    logic [NR-1:0]    we     [2];
    logic [NR*DW-1:0] addr   [2];
    logic [NR*DW-1:0] wdata  [2];
    logic [NR-1:0]    gnt    [2];
    logic [NR-1:0]    rvalid [2];
    logic [DW-1:0]    rdata  [2];
    logic [DW-1:0]    mem_addr  [2];
    logic [DW-1:0]    mem_wdata [2];
    logic [DW-1:0]    mem_rdata [2];
    logic             mem_we [2];
    logic             busy   [2];
    logic [1:0]       gid    [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Memory contents: one fixed word, otherwise address-derived data
    function automatic logic [DW-1:0] mem_model(input logic [DW-1:0] a);
        if (a == 32'h0000_0044) return 32'h1234_5678;
        return a ^ 32'hA5A5_0000;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : 3;
        logic [DW-1:0] pipe [LAT];

        mem_port_arbiter #(
            .NUM_REQ      (NR),
            .DATA_W       (DW),
            .READ_LATENCY (LAT),
            .PRIO0_FIXED  (g == 0)
        ) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .req_i       (req[g]),
            .we_i        (we[g]),
            .addr_i      (addr[g]),
            .wdata_i     (wdata[g]),
            .gnt_o       (gnt[g]),
            .rvalid_o    (rvalid[g]),
            .rdata_o     (rdata[g]),
            .mem_addr_o  (mem_addr[g]),
            .mem_wdata_o (mem_wdata[g]),
            .mem_we_o    (mem_we[g]),
            .mem_rdata_i (mem_rdata[g]),
            .busy_o      (busy[g]),
            .grant_id_o  (gid[g])
        );

        // Block RAM with LAT-cycle read pipeline
        always @(posedge clk) begin
            pipe[0] <= mem_model(mem_addr[g]);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_rdata[g] = pipe[LAT-1];
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input int g, input int i, input logic r, input logic w,
                         input logic [DW-1:0] a, input logic [DW-1:0] d);
        req[g][i] = r;
        we[g][i]  = w;
        addr[g][i*DW +: DW]  = a;
        wdata[g][i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        for (int g = 0; g < 2; g++) begin
            total++;
            if ({gnt[g], rvalid[g], mem_we[g], busy[g], gid[g]} !== 10'b0) begin
                bad++;
                $display("FAIL reset_ctrl[%0d]: got %b want 0", g,
                         {gnt[g], rvalid[g], mem_we[g], busy[g], gid[g]});
            end
            total++;
            if ({rdata[g], mem_addr[g], mem_wdata[g]} !== 96'b0) begin
                bad++;
                $display("FAIL reset_data[%0d]: got %h want 0", g,
                         {rdata[g], mem_addr[g], mem_wdata[g]});
            end
        end
    endtask

    task automatic test_single_write();
        drive(0, 1, 1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
        tick();
        total++;
        if (gnt[0] !== 3'b010) begin bad++; $display("FAIL wr_gnt: got %b want 010", gnt[0]); end
        total++;
        if (mem_we[0] !== 1'b1) begin bad++; $display("FAIL wr_we: got %b want 1", mem_we[0]); end
        total++;
        if (mem_addr[0] !== 32'h40) begin bad++; $display("FAIL wr_addr: got %h want 40", mem_addr[0]); end
        total++;
        if (mem_wdata[0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_wdata: got %h want deadbeef", mem_wdata[0]); end
        total++;
        if ({busy[0], gid[0]} !== 3'b101) begin bad++; $display("FAIL wr_busy_id: got %b want 101", {busy[0], gid[0]}); end
        drive(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        total++;
        if ({mem_we[0], gnt[0], busy[0], rvalid[0]} !== 8'b0) begin
            bad++; $display("FAIL wr_done: got %b want 0", {mem_we[0], gnt[0], busy[0], rvalid[0]});
        end
        tick();
        total++;
        if (rvalid[0] !== 3'b000) begin bad++; $display("FAIL wr_no_rvalid: got %b want 000", rvalid[0]); end
    endtask

    task automatic test_single_read();
        drive(0, 2, 1'b1, 1'b0, 32'h0000_0044, 32'h0);
        tick();
        total++;
        if ({gnt[0], busy[0], mem_we[0], gid[0]} !== 7'b100_1_0_10) begin
            bad++; $display("FAIL rd_issue: got %b want 1001010", {gnt[0], busy[0], mem_we[0], gid[0]});
        end
        total++;
        if (mem_addr[0] !== 32'h44) begin bad++; $display("FAIL rd_addr: got %h want 44", mem_addr[0]); end
        drive(0, 2, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        total++;
        if ({busy[0], gnt[0], rvalid[0], mem_we[0]} !== 8'b1_000_000_0) begin
            bad++; $display("FAIL rd_wait: got %b want 10000000", {busy[0], gnt[0], rvalid[0], mem_we[0]});
        end
        tick();
        total++;
        if (rvalid[0] !== 3'b100) begin bad++; $display("FAIL rd_rvalid: got %b want 100", rvalid[0]); end
        total++;
        if (rdata[0] !== 32'h1234_5678) begin bad++; $display("FAIL rd_rdata: got %h want 12345678", rdata[0]); end
        total++;
        if (busy[0] !== 1'b0) begin bad++; $display("FAIL rd_busy_end: got %b want 0", busy[0]); end
        tick();
        total++;
        if ({rvalid[0], rdata[0]} !== {3'b000, 32'h1234_5678}) begin
            bad++; $display("FAIL rd_hold: got %b/%h want 000/12345678", rvalid[0], rdata[0]);
        end
    endtask

    task automatic test_round_robin();
        int            exp_id [6] = '{0, 1, 2, 0, 1, 2};
        int            ng;
        int            nv;
        int            gcyc;
        int            gown;
        logic [NR-1:0] e;
        logic [DW-1:0] ea;
        ng = 0; nv = 0; gcyc = 0; gown = 0; ea = '0;
        for (int i = 0; i < 3; i++) drive(1, i, 1'b1, 1'b0, 32'h100 + DW'(4*i), 32'h0);
        for (int c = 0; c < 80 && nv < 6; c++) begin
            tick();
            if (gnt[1] !== 3'b000) begin
                gown = (ng < 6) ? exp_id[ng] : 0;
                e    = (ng < 6) ? (3'b001 << gown) : 3'b000;
                ea   = 32'h100 + DW'(4*gown);
                total++;
                if (gnt[1] !== e) begin bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", ng, gnt[1], e); end
                total++;
                if (mem_addr[1] !== ea) begin bad++; $display("FAIL rr_addr[%0d]: got %h want %h", ng, mem_addr[1], ea); end
                gcyc = c;
                ng++;
            end
            if (rvalid[1] !== 3'b000) begin
                e = 3'b001 << gown;
                total++;
                if (rvalid[1] !== e) begin bad++; $display("FAIL rr_rvalid[%0d]: got %b want %b", nv, rvalid[1], e); end
                total++;
                if (c - gcyc != 4) begin bad++; $display("FAIL rr_latency[%0d]: got %0d want 4", nv, c - gcyc); end
                total++;
                if (rdata[1] !== (ea ^ 32'hA5A5_0000)) begin
                    bad++; $display("FAIL rr_rdata[%0d]: got %h want %h", nv, rdata[1], ea ^ 32'hA5A5_0000);
                end
                nv++;
            end
        end
        for (int i = 0; i < 3; i++) drive(1, i, 1'b0, 1'b0, 32'h0, 32'h0);
        total++;
        if (ng != 6 || nv != 6) begin bad++; $display("FAIL rr_count: got %0d gnt %0d rvalid want 6 6", ng, nv); end
        tick();
        tick();
    endtask

    task automatic test_fixed_prio();
        int n0;
        bit seen;
        n0 = 0;
        drive(0, 0, 1'b1, 1'b0, 32'h60, 32'h0);
        drive(0, 1, 1'b1, 1'b0, 32'h64, 32'h0);
        for (int c = 0; c < 12; c++) begin
            tick();
            if (gnt[0] !== 3'b000) begin
                total++;
                if (gnt[0] !== 3'b001) begin bad++; $display("FAIL fp_hold: got %b want 001", gnt[0]); end
                n0++;
            end
        end
        total++;
        if (n0 < 3) begin bad++; $display("FAIL fp_count: got %0d want >=3", n0); end
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (gnt[0] !== 3'b000) begin
                seen = 1'b1;
                total++;
                if (gnt[0] !== 3'b001) begin bad++; $display("FAIL fp_first: got %b want 001", gnt[0]); end
                drive(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (gnt[0] !== 3'b000) begin
                seen = 1'b1;
                total++;
                if (gnt[0] !== 3'b010) begin bad++; $display("FAIL fp_second: got %b want 010", gnt[0]); end
                drive(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL fp_timeout: got no gnt want 010"); end
        tick();
        tick();
        total++;
        if ({rvalid[0], rdata[0]} !== {3'b010, 32'hA5A5_0064}) begin
            bad++; $display("FAIL fp_rdata: got %b/%h want 010/a5a50064", rvalid[0], rdata[0]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(0, 1, 1'b1, 1'b0, 32'h48, 32'h0);
        tick();
        drive(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1, 1'b1, 1'b1, 32'h70, 32'h5555_AAAA);
        tick();
        total++;
        if ({busy[0], mem_we[0]} !== 2'b10) begin bad++; $display("FAIL rm_wait: got %b want 10", {busy[0], mem_we[0]}); end
        total++;
        if ({gnt[1], mem_we[1]} !== 4'b010_1) begin bad++; $display("FAIL rm_b_issue: got %b want 0101", {gnt[1], mem_we[1]}); end
        drive(1, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            total++;
            if ({mem_we[g], gnt[g], rvalid[g], busy[g]} !== 8'b0) begin
                bad++; $display("FAIL rm_async[%0d]: got %b want 0", g, {mem_we[g], gnt[g], rvalid[g], busy[g]});
            end
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if ({rvalid[0], rvalid[1]} !== 6'b0) begin
                bad++; $display("FAIL rm_no_rvalid: got %b want 0", {rvalid[0], rvalid[1]});
            end
        end
        for (int g = 0; g < 2; g++) begin
            drive(g, 1, 1'b1, 1'b0, 32'h80, 32'h0);
            drive(g, 2, 1'b1, 1'b0, 32'h84, 32'h0);
        end
        tick();
        for (int g = 0; g < 2; g++) begin
            total++;
            if (gnt[g] !== 3'b010) begin bad++; $display("FAIL rm_ptr[%0d]: got %b want 010", g, gnt[g]); end
            drive(g, 1, 1'b0, 1'b0, 32'h0, 32'h0);
            drive(g, 2, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        for (int c = 0; c < 6; c++) tick();
    endtask

    task automatic test_back_to_back();
        drive(0, 1, 1'b1, 1'b0, 32'h4C, 32'h0);
        tick();
        total++;
        if (gnt[0] !== 3'b010) begin bad++; $display("FAIL b2b_rd_gnt: got %b want 010", gnt[0]); end
        drive(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(0, 2, 1'b1, 1'b1, 32'h50, 32'hCAFE_F00D);
        tick();
        total++;
        if ({mem_we[0], gnt[0]} !== 4'b0) begin bad++; $display("FAIL b2b_wait: got %b want 0", {mem_we[0], gnt[0]}); end
        tick();
        total++;
        if ({rvalid[0], gnt[0]} !== 6'b010_000) begin bad++; $display("FAIL b2b_rvalid: got %b want 010000", {rvalid[0], gnt[0]}); end
        total++;
        if (rdata[0] !== 32'hA5A5_004C) begin bad++; $display("FAIL b2b_rdata: got %h want a5a5004c", rdata[0]); end
        tick();
        total++;
        if ({gnt[0], rvalid[0], mem_we[0]} !== 7'b100_000_1) begin
            bad++; $display("FAIL b2b_wr_gnt: got %b want 1000001", {gnt[0], rvalid[0], mem_we[0]});
        end
        total++;
        if ({mem_addr[0], mem_wdata[0]} !== {32'h50, 32'hCAFE_F00D}) begin
            bad++; $display("FAIL b2b_wr_data: got %h/%h want 50/cafef00d", mem_addr[0], mem_wdata[0]);
        end
        drive(0, 2, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        total++;
        if ({mem_we[0], busy[0]} !== 2'b00) begin bad++; $display("FAIL b2b_end: got %b want 00", {mem_we[0], busy[0]}); end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            req[g]   = '0;
            we[g]    = '0;
            addr[g]  = '0;
            wdata[g] = '0;
        end
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_single_write();
        test_single_read();
        test_round_robin();
        test_fixed_prio();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
